// File: rtl/key_pkg.sv
// key_pkg: shared channel FSM encoding and counter width helpers for the key debouncer
package key_pkg;
    typedef enum logic [2:0] {IDLE, PRESS_WAIT, PRESSED, HELD, RELEASE_WAIT} key_state_e;
    function automatic int clog2(input int v);
        int r = 0;
        int x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction
    function automatic int cnt_width(input int a, input int b, input int c);
        int m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return clog2(m + 1);
    endfunction
endpackage

// File: rtl/key_debounce_n_if.sv
// key_debounce_n_if: raw key inputs and debounced key event outputs
interface key_debounce_n_if #(parameter int N_KEYS = 8);
    logic [N_KEYS-1:0] key_i;
    logic [N_KEYS-1:0] level_o;
    logic [N_KEYS-1:0] press_o;
    logic [N_KEYS-1:0] release_o;
    logic [N_KEYS-1:0] long_o;
    logic [N_KEYS-1:0] repeat_o;
    logic              any_press_o;
    modport master (output key_i, input level_o, press_o, release_o, long_o, repeat_o, any_press_o);
    modport slave  (input key_i, output level_o, press_o, release_o, long_o, repeat_o, any_press_o);
endinterface

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one key channel with synchronizer, press/long/repeat FSM and private counter
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LONG_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000,
    parameter int REPEAT_EN    = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic press_next
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);
    localparam logic [CNT_W-1:0] DB_T = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LG_T = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] RP_T = CNT_W'(REPEAT_CYC - 1);
    localparam logic INACTIVE = (ACTIVE_LOW != 0);
    logic [1:0] sync;
    logic s;
    key_state_e state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic held, held_d, level_d, release_d, long_d, repeat_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync          <= {2{INACTIVE}};
            s             <= 1'b0;
            state         <= IDLE;
            cnt           <= '0;
            held          <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync          <= {sync[0], key};
            s             <= sync[1] ^ INACTIVE;
            state         <= state_d;
            cnt           <= cnt_d;
            held          <= held_d;
            level         <= level_d;
            press_pulse   <= press_next;
            release_pulse <= release_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
        end
    end
    // held remembers whether RELEASE_WAIT was entered from HELD, so a bounce resumes there
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 1'b1;
        held_d     = held;
        level_d    = level;
        press_next = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        case (state)
            IDLE: begin
                cnt_d   = '0;
                state_d = s ? PRESS_WAIT : IDLE;
            end
            PRESS_WAIT:
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt == DB_T) begin
                    state_d    = PRESSED;
                    cnt_d      = '0;
                    held_d     = 1'b0;
                    level_d    = 1'b1;
                    press_next = 1'b1;
                end
            PRESSED:
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                    held_d  = 1'b0;
                end else if (cnt == LG_T) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end
            HELD:
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                    held_d  = 1'b1;
                end else if (cnt == RP_T) begin
                    cnt_d    = '0;
                    repeat_d = (REPEAT_EN != 0);
                end
            RELEASE_WAIT:
                if (s) begin
                    state_d = held ? HELD : PRESSED;
                    cnt_d   = '0;
                end else if (cnt == DB_T) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule

// File: rtl/key_debounce_n.sv
// key_debounce_n: N independent debounced key channels with a combined press indicator
module key_debounce_n #(
    parameter int N_KEYS       = 8,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LONG_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000,
    parameter int REPEAT_EN    = 1,
    parameter int ACTIVE_LOW   = 1
) (
    input logic clk,
    input logic rst,
    key_debounce_n_if.slave bus
);
    logic [N_KEYS-1:0] press_next;
    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC(LONG_CYC),
            .REPEAT_CYC(REPEAT_CYC),
            .REPEAT_EN(REPEAT_EN),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_chan (
            .clk(clk),
            .rst(rst),
            .key(bus.key_i[i]),
            .level(bus.level_o[i]),
            .press_pulse(bus.press_o[i]),
            .release_pulse(bus.release_o[i]),
            .long_pulse(bus.long_o[i]),
            .repeat_pulse(bus.repeat_o[i]),
            .press_next(press_next[i])
        );
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.any_press_o <= 1'b0;
        else     bus.any_press_o <= |press_next;
    end
endmodule

// File: tb/tb_key_debounce_n.sv
// tb_key_debounce_n: directed stimulus checked against a run-length key model and literal timings
module tb_key_debounce_n;
    localparam int NK = 4, DB = 4, LG = 16, RP = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0, n_fail = 0;
    int pc1 = 0, rc2 = 0, lcb = 0, rcb = 0;
    always #5 clk = ~clk;
    key_debounce_n_if #(.N_KEYS(NK)) a();
    key_debounce_n_if #(.N_KEYS(NK)) b();
    key_debounce_n #(.N_KEYS(NK), .DEBOUNCE_CYC(DB), .LONG_CYC(LG), .REPEAT_CYC(RP),
                     .REPEAT_EN(1), .ACTIVE_LOW(1)) dut (.clk(clk), .rst(rst), .bus(a.slave));
    key_debounce_n #(.N_KEYS(NK), .DEBOUNCE_CYC(DB), .LONG_CYC(LG), .REPEAT_CYC(RP),
                     .REPEAT_EN(0), .ACTIVE_LOW(1)) dut_nr (.clk(clk), .rst(rst), .bus(b.slave));
    // model: a key is accepted after DB+1 consecutive pressed samples, released after DB+1 released ones
    typedef struct {
        bit acc, held;
        int ones, zeros, t;
        bit press, rel, lng, rpt;
    } mch_t;
    mch_t m[8];
    bit [2:0] h[8];
    logic [7:0] raw;
    assign raw = ~{b.key_i, a.key_i};
    function automatic mch_t step_model(mch_t c, bit d, bit ren);
        mch_t n = c;
        n.press = 0; n.rel = 0; n.lng = 0; n.rpt = 0;
        if (!c.acc) begin
            n.ones = d ? c.ones + 1 : 0;
            if (n.ones == DB + 1) begin
                n.acc = 1; n.press = 1; n.held = 0; n.t = 0; n.ones = 0;
            end
        end else if (!d) begin
            n.zeros = c.zeros + 1;
            if (n.zeros == DB + 1) begin
                n.acc = 0; n.rel = 1; n.zeros = 0;
            end
        end else if (c.zeros > 0) begin
            n.zeros = 0; n.t = 0;
        end else begin
            n.t = c.t + 1;
            if (!c.held && n.t == LG) begin
                n.held = 1; n.lng = 1; n.t = 0;
            end else if (c.held && n.t == RP) begin
                n.rpt = ren; n.t = 0;
            end
        end
        return n;
    endfunction
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                m[k] <= '{default: 0};
                h[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                m[k] <= step_model(m[k], h[k][2], k < 4);
                h[k] <= {h[k][1:0], raw[k]};
            end
        end
    end
    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic chkn(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        logic [3:0] el, ep, er, eg, et;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                el[k] = m[d*4+k].acc;
                ep[k] = m[d*4+k].press;
                er[k] = m[d*4+k].rel;
                eg[k] = m[d*4+k].lng;
                et[k] = m[d*4+k].rpt;
            end
            chk($sformatf("%s_level", d ? "b" : "a"), d ? b.level_o : a.level_o, el);
            chk($sformatf("%s_press", d ? "b" : "a"), d ? b.press_o : a.press_o, ep);
            chk($sformatf("%s_release", d ? "b" : "a"), d ? b.release_o : a.release_o, er);
            chk($sformatf("%s_long", d ? "b" : "a"), d ? b.long_o : a.long_o, eg);
            chk($sformatf("%s_repeat", d ? "b" : "a"), d ? b.repeat_o : a.repeat_o, et);
            chk($sformatf("%s_any", d ? "b" : "a"), {3'b0, d ? b.any_press_o : a.any_press_o}, {3'b0, |ep});
        end
        pc1 += int'(a.press_o[1]);
        rc2 += int'(a.release_o[2]);
        lcb += int'(b.long_o[0]);
        rcb += int'(b.repeat_o[0]);
    end
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        int p0, r0, l0, q0;
        a.key_i = 4'hF;
        b.key_i = 4'hF;
        #2 rst = 1'b1;
        #1 chk("rst_level", a.level_o, 4'b0000);
        chk("rst_press", a.press_o, 4'b0000);
        chk("rst_any", {3'b0, a.any_press_o}, 4'b0000);
        step(2);
        rst = 1'b0;
        step(2);
        chk("idle_level", a.level_o, 4'b0000);
        // single press held 40 cycles: press, long, two repeats, release
        a.key_i[0] = 1'b0;
        step(7);
        chk("A_press_early", a.press_o, 4'b0000);
        step(1);
        chk("A_press", a.press_o, 4'b0001);
        chk("A_any", {3'b0, a.any_press_o}, 4'b0001);
        chk("A_level", a.level_o, 4'b0001);
        step(1);
        chk("A_press_once", a.press_o, 4'b0000);
        step(15);
        chk("A_long", a.long_o, 4'b0001);
        step(8);
        chk("A_repeat1", a.repeat_o, 4'b0001);
        chk("A_long_quiet", a.long_o, 4'b0000);
        step(8);
        chk("A_repeat2", a.repeat_o, 4'b0001);
        a.key_i[0] = 1'b1;
        step(7);
        chk("A_release_early", a.release_o, 4'b0000);
        step(1);
        chk("A_release", a.release_o, 4'b0001);
        chk("A_level_off", a.level_o, 4'b0000);
        step(4);
        // short low glitches must never be accepted
        p0 = pc1;
        a.key_i[1] = 1'b0; step(1); a.key_i[1] = 1'b1; step(3);
        a.key_i[1] = 1'b0; step(2); a.key_i[1] = 1'b1; step(3);
        a.key_i[1] = 1'b0; step(3); a.key_i[1] = 1'b1; step(12);
        chkn("B_press_cnt", pc1 - p0, 0);
        chk("B_level", {3'b0, a.level_o[1]}, 4'b0000);
        // release bounce while pressed delays long press to 16 cycles after the bounce ends
        r0 = rc2;
        a.key_i[2] = 1'b0;
        step(8);
        chk("C_press", a.press_o, 4'b0100);
        step(5);
        a.key_i[2] = 1'b1;
        step(2);
        a.key_i[2] = 1'b0;
        step(19);
        chk("C_long_late", a.long_o, 4'b0000);
        step(1);
        chk("C_long", a.long_o, 4'b0100);
        chk("C_level", {3'b0, a.level_o[2]}, 4'b0001);
        chkn("C_release_cnt", rc2 - r0, 0);
        a.key_i[2] = 1'b1;
        step(12);
        // simultaneous presses on two channels
        a.key_i = 4'b0110;
        step(8);
        chk("D_press", a.press_o, 4'b1001);
        chk("D_any", {3'b0, a.any_press_o}, 4'b0001);
        a.key_i = 4'hF;
        step(12);
        // reset mid-press drops level silently, then the held key is re-accepted
        a.key_i[1] = 1'b0;
        step(12);
        chk("E_level_before", a.level_o, 4'b0010);
        #2 rst = 1'b1;
        #1 chk("E_level_rst", a.level_o, 4'b0000);
        chk("E_release_rst", a.release_o, 4'b0000);
        step(2);
        rst = 1'b0;
        step(7);
        chk("E_press_early", a.press_o, 4'b0000);
        step(1);
        chk("E_press", a.press_o, 4'b0010);
        a.key_i[1] = 1'b1;
        step(12);
        // auto-repeat disabled: one long pulse, no repeats
        l0 = lcb;
        q0 = rcb;
        b.key_i[0] = 1'b0;
        step(24);
        chk("F_long", b.long_o, 4'b0001);
        step(36);
        b.key_i[0] = 1'b1;
        step(12);
        chkn("F_long_cnt", lcb - l0, 1);
        chkn("F_repeat_cnt", rcb - q0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/key_debounce_n.md
KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

Interface
REQ-001 Parameter N_KEYS, default 8, number of independent key channels (1..32).
REQ-002 Parameter DEBOUNCE_CYC, default 1000000, stable-sample cycles required to accept a press or release (>=1).
REQ-003 Parameter LONG_CYC, default 50000000, cycles of accepted press before the long-press event (>=1).
REQ-004 Parameter REPEAT_CYC, default 10000000, auto-repeat period after long press (>=1).
REQ-005 Parameter REPEAT_EN, default 1, 1 enables auto-repeat pulses, 0 suppresses them.
REQ-006 Parameter ACTIVE_LOW, default 1, 1 means a raw 0 on a key input is "pressed".
REQ-007 clk  input  1  single system clock, all logic rising-edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 key_i  input  N_KEYS  raw asynchronous key inputs, bit k = channel k.
REQ-010 level_o  output  N_KEYS  debounced pressed state, 1 = pressed.
REQ-011 press_o  output  N_KEYS  one-cycle pulse on accepted press.
REQ-012 release_o  output  N_KEYS  one-cycle pulse on accepted release.
REQ-013 long_o  output  N_KEYS  one-cycle pulse when press held LONG_CYC.
REQ-014 repeat_o  output  N_KEYS  one-cycle pulse every REPEAT_CYC while in long-hold.
REQ-015 any_press_o  output  1  registered OR of press_o, same cycle as press_o.

Function
REQ-016 Each key_i bit SHALL pass through a 2-flop synchronizer; sample s = synced bit XOR ACTIVE_LOW gives s=1 for pressed.
REQ-017 Each channel SHALL own a private counter of width CNT_W = clog2(max(DEBOUNCE_CYC,LONG_CYC,REPEAT_CYC)+1); channels never share counters.
REQ-018 Channel FSM states: IDLE, PRESS_WAIT, PRESSED, HELD, RELEASE_WAIT.
REQ-019 IDLE: s=1 -> PRESS_WAIT, cnt=0; else stay.
REQ-020 PRESS_WAIT: s=0 -> IDLE; s=1 with cnt==DEBOUNCE_CYC-1 -> PRESSED, cnt=0, press_o pulse, level_o=1; else cnt+1.
REQ-021 PRESSED: s=0 -> RELEASE_WAIT, cnt=0; s=1 with cnt==LONG_CYC-1 -> HELD, cnt=0, long_o pulse; else cnt+1.
REQ-022 HELD: s=0 -> RELEASE_WAIT, cnt=0; s=1 with cnt==REPEAT_CYC-1 -> cnt=0, repeat_o pulse if REPEAT_EN; else cnt+1.
REQ-023 RELEASE_WAIT: s=1 -> return to PRESSED or HELD (whichever was left, held in a 1-bit flag), cnt=0, no pulses; s=0 with cnt==DEBOUNCE_CYC-1 -> IDLE, release_o pulse, level_o=0; else cnt+1.
REQ-024 Returning from RELEASE_WAIT to PRESSED SHALL restart the long-press count from 0 (bounce extends long-press time).
REQ-025 All outputs SHALL be registered; a raw press stable from before edge 0 SHALL yield press_o high in the cycle after edge DEBOUNCE_CYC+3.
REQ-026 Counters SHALL never wrap: every compare-and-clear happens at the terminal value listed above.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels SHALL each pulse in their own bit in the same cycle.
REQ-028 press_o and release_o SHALL never be high together on one channel; long_o and repeat_o SHALL never be high together on one channel.

Reset
REQ-029 While rst=1: synchronizer flops SHALL load the inactive level (ACTIVE_LOW ? 1 : 0), all FSMs IDLE, counters 0, every output 0.
REQ-030 Reset asserted mid-press SHALL drop level_o to 0 without a release_o pulse; after deassertion a still-held key SHALL be re-accepted with full debounce and a fresh press_o.

Structure
REQ-031 Shared package key_pkg SHALL hold the FSM state encoding and the clog2 width function.
REQ-032 One sub-module key_debounce_chan (synchronizer + FSM + counter, one channel) SHALL be instantiated N_KEYS times by generate loop; top adds only any_press_o.

Verification (DEBOUNCE_CYC=4, LONG_CYC=16, REPEAT_CYC=8, N_KEYS=4, ACTIVE_LOW=1)
REQ-033 key_i[0] 1->0 held 40 cycles -> press_o[0] one pulse 7 cycles after edge, long_o[0] 16 cycles later, repeat_o[0] every 8 cycles after that.
REQ-034 key_i[1] low-glitches of 1,2,3 cycles -> no press_o, level_o[1] stays 0.
REQ-035 key_i[2] pressed, then 2-cycle high bounce during PRESSED -> no release_o, level_o[2] stays 1, long_o delayed by bounce time.
REQ-036 key_i[0] and key_i[3] pressed same cycle -> press_o=4'b1001 in one cycle, any_press_o=1 that cycle.
REQ-037 rst pulsed while key_i[1] held pressed -> level_o[1]=0 immediately, no release_o; press_o[1] again 7 cycles after rst falls.
REQ-038 REPEAT_EN=0, key held 60 cycles -> long_o one pulse, repeat_o stays 0.
